// File: rtl/exop_dual_issue_ctl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : exop_dual_issue_ctl_pkg
// Brief    : Shared opcode, register-id and state definitions for the
//            dual-issue controller and its scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
package exop_dual_issue_ctl_pkg;

    // Register id that means "no register"; never tracked as busy.
    localparam logic [6:0] UREG_ZZR      = 7'h7F;

    // Primary-unit memory status codes.
    localparam logic [1:0] UMEM_OK_READY = 2'd0;
    localparam logic [1:0] UMEM_OK_HOLD  = 2'd1;
    localparam logic [1:0] UMEM_OK_FAULT = 2'd2;

    // Micro-op encodings.
    localparam logic [7:0] UCMD_NONE   = 8'h00;
    localparam logic [7:0] UCMD_MOV_RR = 8'h01;
    localparam logic [7:0] UCMD_MOV_RI = 8'h02;
    localparam logic [7:0] UCMD_ADD    = 8'h03;
    localparam logic [7:0] UCMD_SUB    = 8'h04;
    localparam logic [7:0] UCMD_AND    = 8'h05;
    localparam logic [7:0] UCMD_OR     = 8'h06;
    localparam logic [7:0] UCMD_XOR    = 8'h07;
    localparam logic [7:0] UCMD_NOT    = 8'h08;
    localparam logic [7:0] UCMD_SWAPB  = 8'h09;
    localparam logic [7:0] UCMD_SWAPW  = 8'h0A;
    localparam logic [7:0] UCMD_EXTUB  = 8'h0B;
    localparam logic [7:0] UCMD_EXTUW  = 8'h0C;
    localparam logic [7:0] UCMD_EXTSB  = 8'h0D;
    localparam logic [7:0] UCMD_EXTSW  = 8'h0E;
    localparam logic [7:0] UCMD_NEG    = 8'h0F;
    localparam logic [7:0] UCMD_LDSH16 = 8'h10;
    localparam logic [7:0] UCMD_ADDC   = 8'h11;
    localparam logic [7:0] UCMD_SUBC   = 8'h12;
    localparam logic [7:0] UCMD_NEGC   = 8'h13;
    localparam logic [7:0] UCMD_ADDV   = 8'h14;
    localparam logic [7:0] UCMD_SUBV   = 8'h15;
    localparam logic [7:0] UCMD_SHAD   = 8'h16;
    localparam logic [7:0] UCMD_SHLD   = 8'h17;
    localparam logic [7:0] UCMD_MUL    = 8'h18;
    localparam logic [7:0] UCMD_LDB    = 8'h20;
    localparam logic [7:0] UCMD_LDW    = 8'h21;
    localparam logic [7:0] UCMD_LDL    = 8'h22;
    localparam logic [7:0] UCMD_STB    = 8'h28;
    localparam logic [7:0] UCMD_STW    = 8'h29;
    localparam logic [7:0] UCMD_STL    = 8'h2A;
    localparam logic [7:0] UCMD_LDSR   = 8'h30;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_SPLIT = 1'b1
    } issue_state_e;

    // Ops the ALU-only secondary unit can execute; SR-writing arithmetic is
    // excluded because the secondary unit drops SR effects.
    function automatic logic is_sec_capable(input logic [7:0] op);
        return op inside {UCMD_MOV_RR, UCMD_MOV_RI, UCMD_ADD, UCMD_SUB,
                          UCMD_AND, UCMD_OR, UCMD_XOR, UCMD_NOT,
                          UCMD_SWAPB, UCMD_SWAPW, UCMD_EXTUB, UCMD_EXTUW,
                          UCMD_EXTSB, UCMD_EXTSW, UCMD_NEG, UCMD_LDSH16};
    endfunction

    // Ops whose destination stays busy for several cycles after issue.
    function automatic logic is_long_lat(input logic [7:0] op);
        return op inside {UCMD_MUL, UCMD_LDB, UCMD_LDW, UCMD_LDL};
    endfunction

endpackage
`default_nettype wire

// File: rtl/exop_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : exop_issue_scoreboard
// Brief    : Per-register countdown scoreboard for long-latency destinations,
//            with two 3-read busy lookups (one per issue slot).
// Revision : 1.0 - initial release
// ============================================================================
module exop_issue_scoreboard
    import exop_dual_issue_ctl_pkg::*;
#(
    parameter int NREG     = 128,
    parameter int LONG_LAT = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       setValid,
    input  logic [6:0] setId,
    input  logic       freeze,
    input  logic [6:0] s0Rs,
    input  logic [6:0] s0Rt,
    input  logic [6:0] s0Rn,
    input  logic [6:0] s1Rs,
    input  logic [6:0] s1Rt,
    input  logic [6:0] s1Rn,
    output logic       s0Busy,
    output logic       s1Busy
);

    logic [2:0] cnt_q [NREG];
    logic [2:0] cnt_d [NREG];

    // ZZR is excluded explicitly so it can never report busy.
    assign s0Busy = ((s0Rs != UREG_ZZR) && (cnt_q[s0Rs] != 3'd0)) ||
                    ((s0Rt != UREG_ZZR) && (cnt_q[s0Rt] != 3'd0)) ||
                    ((s0Rn != UREG_ZZR) && (cnt_q[s0Rn] != 3'd0));
    assign s1Busy = ((s1Rs != UREG_ZZR) && (cnt_q[s1Rs] != 3'd0)) ||
                    ((s1Rt != UREG_ZZR) && (cnt_q[s1Rt] != 3'd0)) ||
                    ((s1Rn != UREG_ZZR) && (cnt_q[s1Rn] != 3'd0));

    // Countdown unless the primary is holding; a new set overrides the decrement.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!freeze && (cnt_q[i] != 3'd0)) begin
                cnt_d[i] = cnt_q[i] - 3'd1;
            end
            if (setValid && (setId == 7'(i)) && (setId != UREG_ZZR)) begin
                cnt_d[i] = 3'(LONG_LAT);
            end
        end
    end

    // Counter storage, cleared on reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= 3'd0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/exop_dual_issue_ctl.sv
`default_nettype none
// ============================================================================
// Module   : exop_dual_issue_ctl
// Brief    : ID -> EX issue controller. Dual-issues a decoded pair to the
//            primary and ALU-only secondary units, splits it over two cycles,
//            or stalls on long-latency hazards / primary hold.
//            Optional: EXOP_ISSUE_STATS_EN enables saturating counters of
//            dual-issue, split-issue and stall cycles.
// Revision : 1.0 - initial release
// ============================================================================
module exop_dual_issue_ctl
    import exop_dual_issue_ctl_pkg::*;
#(
    parameter int LONG_LAT = 3,
    parameter int NREG     = 128,
    parameter int STAT_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              idValid,
    input  logic [7:0]        idOpA,
    input  logic [6:0]        idRsA,
    input  logic [6:0]        idRtA,
    input  logic [6:0]        idRnA,
    input  logic [7:0]        idOpB,
    input  logic [6:0]        idRsB,
    input  logic [6:0]        idRtB,
    input  logic [6:0]        idRnB,
    output logic              idReady,
    input  logic              exHold,
    output logic              priValid,
    output logic [7:0]        priOp,
    output logic [6:0]        priRs,
    output logic [6:0]        priRt,
    output logic [6:0]        priRn,
    output logic              secValid,
    output logic [7:0]        secOp,
    output logic [6:0]        secRs,
    output logic [6:0]        secRt,
    output logic [6:0]        secRn,
    output logic [STAT_W-1:0] statPair,
    output logic [STAT_W-1:0] statSplit,
    output logic [STAT_W-1:0] statStall
);

    issue_state_e state_q, state_d;
    logic [7:0]   held_op_q, held_op_d;
    logic [6:0]   held_rs_q, held_rs_d, held_rt_q, held_rt_d, held_rn_q, held_rn_d;
    logic         pri_valid_q, pri_valid_d, sec_valid_q, sec_valid_d;
    logic [7:0]   pri_op_q, pri_op_d, sec_op_q, sec_op_d;
    logic [6:0]   pri_rs_q, pri_rs_d, pri_rt_q, pri_rt_d, pri_rn_q, pri_rn_d;
    logic [6:0]   sec_rs_q, sec_rs_d, sec_rt_q, sec_rt_d, sec_rn_q, sec_rn_d;

    logic [7:0]   a_op, b_op;
    logic [6:0]   a_rs, a_rt, a_rn, b_rs, b_rt, b_rn;
    logic [6:0]   s0_rs, s0_rt, s0_rn;
    logic         haz0, haz1, b_empty, pairable, ready_w;

    // Promote B into A when A is empty so a lone op always uses the primary.
    always_comb begin
        if ((idOpA == UCMD_NONE) && (idOpB != UCMD_NONE)) begin
            a_op = idOpB;     a_rs = idRsB;    a_rt = idRtB;    a_rn = idRnB;
            b_op = UCMD_NONE; b_rs = UREG_ZZR; b_rt = UREG_ZZR; b_rn = UREG_ZZR;
        end else begin
            a_op = idOpA;     a_rs = idRsA;    a_rt = idRtA;    a_rn = idRnA;
            b_op = idOpB;     b_rs = idRsB;    b_rt = idRtB;    b_rn = idRnB;
        end
    end

    // Lookup port 0 checks the held op while split, otherwise slot A.
    assign s0_rs = (state_q == ST_SPLIT) ? held_rs_q : a_rs;
    assign s0_rt = (state_q == ST_SPLIT) ? held_rt_q : a_rt;
    assign s0_rn = (state_q == ST_SPLIT) ? held_rn_q : a_rn;

    exop_issue_scoreboard #(
        .NREG     (NREG),
        .LONG_LAT (LONG_LAT)
    ) u_scoreboard (
        .clock    (clock),
        .reset    (reset),
        .setValid (pri_valid_d && is_long_lat(pri_op_d)),
        .setId    (pri_rn_d),
        .freeze   (exHold),
        .s0Rs     (s0_rs),
        .s0Rt     (s0_rt),
        .s0Rn     (s0_rn),
        .s1Rs     (b_rs),
        .s1Rt     (b_rt),
        .s1Rn     (b_rn),
        .s0Busy   (haz0),
        .s1Busy   (haz1)
    );

    // B may go to the secondary only if capable, independent of A, and hazard-free.
    always_comb begin
        b_empty  = (b_op == UCMD_NONE);
        pairable = b_empty ||
                   (is_sec_capable(b_op) &&
                    (a_rn != b_rs) && (a_rn != b_rt) &&
                    ((a_rn != b_rn) || (a_rn == UREG_ZZR)) &&
                    !haz1);
    end

    // Issue decision: next state, held slot and next issue-register values.
    always_comb begin
        state_d     = state_q;
        held_op_d   = held_op_q;  held_rs_d = held_rs_q;
        held_rt_d   = held_rt_q;  held_rn_d = held_rn_q;
        pri_valid_d = 1'b0;
        pri_op_d    = pri_op_q;   pri_rs_d  = pri_rs_q;
        pri_rt_d    = pri_rt_q;   pri_rn_d  = pri_rn_q;
        sec_valid_d = 1'b0;
        sec_op_d    = sec_op_q;   sec_rs_d  = sec_rs_q;
        sec_rt_d    = sec_rt_q;   sec_rn_d  = sec_rn_q;
        ready_w     = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (idValid && !exHold && !haz0) begin
                    ready_w     = 1'b1;
                    pri_valid_d = (a_op != UCMD_NONE);
                    pri_op_d    = a_op; pri_rs_d = a_rs; pri_rt_d = a_rt; pri_rn_d = a_rn;
                    if (pairable) begin
                        if (!b_empty) begin
                            sec_valid_d = 1'b1;
                            sec_op_d    = b_op; sec_rs_d = b_rs; sec_rt_d = b_rt; sec_rn_d = b_rn;
                        end
                    end else begin
                        held_op_d = b_op; held_rs_d = b_rs; held_rt_d = b_rt; held_rn_d = b_rn;
                        state_d   = ST_SPLIT;
                    end
                end
            end
            ST_SPLIT: begin
                if (!exHold && !haz0) begin
                    pri_valid_d = 1'b1;
                    pri_op_d    = held_op_q; pri_rs_d = held_rs_q;
                    pri_rt_d    = held_rt_q; pri_rn_d = held_rn_q;
                    held_op_d   = UCMD_NONE; held_rs_d = UREG_ZZR;
                    held_rt_d   = UREG_ZZR;  held_rn_d = UREG_ZZR;
                    state_d     = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // FSM, held slot and registered issue outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            held_op_q   <= UCMD_NONE; held_rs_q <= UREG_ZZR;
            held_rt_q   <= UREG_ZZR;  held_rn_q <= UREG_ZZR;
            pri_valid_q <= 1'b0;
            pri_op_q    <= UCMD_NONE; pri_rs_q  <= UREG_ZZR;
            pri_rt_q    <= UREG_ZZR;  pri_rn_q  <= UREG_ZZR;
            sec_valid_q <= 1'b0;
            sec_op_q    <= UCMD_NONE; sec_rs_q  <= UREG_ZZR;
            sec_rt_q    <= UREG_ZZR;  sec_rn_q  <= UREG_ZZR;
        end else begin
            state_q     <= state_d;
            held_op_q   <= held_op_d; held_rs_q <= held_rs_d;
            held_rt_q   <= held_rt_d; held_rn_q <= held_rn_d;
            pri_valid_q <= pri_valid_d;
            pri_op_q    <= pri_op_d;  pri_rs_q  <= pri_rs_d;
            pri_rt_q    <= pri_rt_d;  pri_rn_q  <= pri_rn_d;
            sec_valid_q <= sec_valid_d;
            sec_op_q    <= sec_op_d;  sec_rs_q  <= sec_rs_d;
            sec_rt_q    <= sec_rt_d;  sec_rn_q  <= sec_rn_d;
        end
    end

    // Acceptance is masked while reset is held so ID never sees a stray handshake.
    assign idReady  = ready_w && reset;
    assign priValid = pri_valid_q;
    assign priOp    = pri_op_q;
    assign priRs    = pri_rs_q;
    assign priRt    = pri_rt_q;
    assign priRn    = pri_rn_q;
    assign secValid = sec_valid_q;
    assign secOp    = sec_op_q;
    assign secRs    = sec_rs_q;
    assign secRt    = sec_rt_q;
    assign secRn    = sec_rn_q;

`ifdef EXOP_ISSUE_STATS_EN
    logic [STAT_W-1:0] stat_pair_q, stat_pair_d, stat_split_q, stat_split_d;
    logic [STAT_W-1:0] stat_stall_q, stat_stall_d;
    logic              pair_inc, split_inc, stall_inc;

    // Saturating event counters; a stall is a primary hold, an A-hazard or a SPLIT wait.
    always_comb begin
        pair_inc     = sec_valid_d;
        split_inc    = (state_q == ST_RUN) && (state_d == ST_SPLIT);
        stall_inc    = ((state_q == ST_SPLIT) && (state_d == ST_SPLIT)) ||
                       ((state_q == ST_RUN) && (exHold || (idValid && haz0)));
        stat_pair_d  = (pair_inc  && !(&stat_pair_q))  ? stat_pair_q  + STAT_W'(1) : stat_pair_q;
        stat_split_d = (split_inc && !(&stat_split_q)) ? stat_split_q + STAT_W'(1) : stat_split_q;
        stat_stall_d = (stall_inc && !(&stat_stall_q)) ? stat_stall_q + STAT_W'(1) : stat_stall_q;
    end

    // Counter storage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_pair_q  <= '0;
            stat_split_q <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_pair_q  <= stat_pair_d;
            stat_split_q <= stat_split_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign statPair  = stat_pair_q;
    assign statSplit = stat_split_q;
    assign statStall = stat_stall_q;
`else
    assign statPair  = '0;
    assign statSplit = '0;
    assign statStall = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_exop_dual_issue_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_exop_dual_issue_ctl
// Brief    : Self-checking bench for exop_dual_issue_ctl: vector table,
//            multi-cycle corner sequences and a randomized run against a
//            behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exop_dual_issue_ctl;
    import exop_dual_issue_ctl_pkg::*;

    localparam int LL = 3;
    localparam logic [6:0] Z = UREG_ZZR;

    typedef struct packed {
        logic [7:0] op;
        logic [6:0] rs;
        logic [6:0] rt;
        logic [6:0] rn;
    } slot_t;

    typedef struct {
        bit v; bit h; slot_t a; slot_t b;
        bit rdy; bit pv; logic [7:0] pop; logic [6:0] prn;
        bit sv; logic [7:0] sop; logic [6:0] srn;
    } vec_t;

    logic clock, reset, idValid, exHold, idReady;
    logic [7:0] idOpA, idOpB;
    logic [6:0] idRsA, idRtA, idRnA, idRsB, idRtB, idRnB;
    logic priValid, secValid;
    logic [7:0] priOp, secOp;
    logic [6:0] priRs, priRt, priRn, secRs, secRt, secRn;
    logic [31:0] statPair, statSplit, statStall;

    int n_pass = 0;
    int n_total = 0;

    exop_dual_issue_ctl #(.LONG_LAT(LL), .NREG(128), .STAT_W(32)) dut (
        .clock(clock), .reset(reset), .idValid(idValid),
        .idOpA(idOpA), .idRsA(idRsA), .idRtA(idRtA), .idRnA(idRnA),
        .idOpB(idOpB), .idRsB(idRsB), .idRtB(idRtB), .idRnB(idRnB),
        .idReady(idReady), .exHold(exHold),
        .priValid(priValid), .priOp(priOp), .priRs(priRs), .priRt(priRt), .priRn(priRn),
        .secValid(secValid), .secOp(secOp), .secRs(secRs), .secRt(secRt), .secRn(secRn),
        .statPair(statPair), .statSplit(statSplit), .statStall(statStall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic slot_t sl(logic [7:0] op, logic [6:0] rn, logic [6:0] rs, logic [6:0] rt);
        slot_t s;
        s.op = op; s.rn = rn; s.rs = rs; s.rt = rt;
        return s;
    endfunction

    function automatic vec_t mk(bit v, bit h, slot_t a, slot_t b, bit rdy,
                                bit pv, logic [7:0] pop, logic [6:0] prn,
                                bit sv, logic [7:0] sop, logic [6:0] srn);
        vec_t r;
        r.v = v; r.h = h; r.a = a; r.b = b; r.rdy = rdy;
        r.pv = pv; r.pop = pop; r.prn = prn; r.sv = sv; r.sop = sop; r.srn = srn;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        else n_pass++;
    endtask

    slot_t cur_a, cur_b;

    task automatic drive(input bit v, input bit h, input slot_t a, input slot_t b);
        cur_a = a; cur_b = b;
        idValid = v; exHold = h;
        idOpA = a.op; idRsA = a.rs; idRtA = a.rt; idRnA = a.rn;
        idOpB = b.op; idRsB = b.rs; idRtB = b.rt; idRnB = b.rn;
    endtask

    // Called just after a falling edge; returns idReady seen before the rising edge.
    task automatic cyc(input bit v, input bit h, input slot_t a, input slot_t b, output bit rdy);
        drive(v, h, a, b);
        #1 rdy = idReady;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk_out(input string tag, input bit pv, input logic [7:0] pop, input logic [6:0] prn,
                           input bit sv, input logic [7:0] sop, input logic [6:0] srn);
        chk({tag, "_priValid"}, 32'(priValid), 32'(pv));
        if (pv) begin
            chk({tag, "_priOp"}, 32'(priOp), 32'(pop));
            chk({tag, "_priRn"}, 32'(priRn), 32'(prn));
        end
        chk({tag, "_secValid"}, 32'(secValid), 32'(sv));
        if (sv) begin
            chk({tag, "_secOp"}, 32'(secOp), 32'(sop));
            chk({tag, "_secRn"}, 32'(secRn), 32'(srn));
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Busy tracking uses a "virtual time" that only advances on non-hold
    // cycles; a register is busy until virtual time reaches its ready time.
    int unsigned vt;
    int unsigned rdy_at [128];
    bit    m_held_v, m_ready, e_pv, e_sv;
    slot_t m_held, e_pri, e_sec;

    function automatic bit m_busy(logic [6:0] id);
        return (id != Z) && (rdy_at[id] > vt);
    endfunction
    function automatic bit m_haz(slot_t s);
        return m_busy(s.rs) || m_busy(s.rt) || m_busy(s.rn);
    endfunction
    function automatic bit m_sec(logic [7:0] op);
        return op inside {UCMD_MOV_RR, UCMD_MOV_RI, UCMD_ADD, UCMD_SUB, UCMD_AND, UCMD_OR,
                          UCMD_XOR, UCMD_NOT, UCMD_SWAPB, UCMD_SWAPW, UCMD_EXTUB, UCMD_EXTUW,
                          UCMD_EXTSB, UCMD_EXTSW, UCMD_NEG, UCMD_LDSH16};
    endfunction
    function automatic bit m_long(logic [7:0] op);
        return op inside {UCMD_MUL, UCMD_LDB, UCMD_LDW, UCMD_LDL};
    endfunction

    task automatic m_reset();
        vt = 0;
        for (int i = 0; i < 128; i++) rdy_at[i] = 0;
        m_held_v = 0; e_pv = 0; e_sv = 0;
    endtask

    task automatic m_cycle();
        slot_t a, b;
        m_ready = 0; e_pv = 0; e_sv = 0;
        if (m_held_v) begin
            if (!exHold && !m_haz(m_held)) begin
                e_pv = 1; e_pri = m_held; m_held_v = 0;
            end
        end else if (idValid && !exHold) begin
            a = cur_a; b = cur_b;
            if (a.op == UCMD_NONE && b.op != UCMD_NONE) begin
                a = b; b = sl(UCMD_NONE, Z, Z, Z);
            end
            if (!m_haz(a)) begin
                m_ready = 1;
                e_pri = a; e_pv = (a.op != UCMD_NONE);
                if (b.op != UCMD_NONE) begin
                    if (m_sec(b.op) && a.rn != b.rs && a.rn != b.rt &&
                        !(a.rn == b.rn && a.rn != Z) && !m_haz(b)) begin
                        e_sv = 1; e_sec = b;
                    end else begin
                        m_held = b; m_held_v = 1;
                    end
                end
            end
        end
        if (e_pv && m_long(e_pri.op) && e_pri.rn != Z) rdy_at[e_pri.rn] = vt + LL + 1;
        if (!exHold) vt++;
    endtask

    function automatic slot_t rnd_slot();
        logic [7:0] ops [14];
        slot_t s;
        ops = '{UCMD_NONE, UCMD_MOV_RR, UCMD_MOV_RI, UCMD_ADD, UCMD_SUB, UCMD_XOR, UCMD_NEG,
                UCMD_LDSH16, UCMD_ADDC, UCMD_SUBV, UCMD_SHAD, UCMD_MUL, UCMD_LDL, UCMD_STL};
        s.op = ops[$urandom_range(0, 13)];
        s.rs = ($urandom_range(0, 7) == 0) ? Z : 7'($urandom_range(0, 9));
        s.rt = ($urandom_range(0, 7) == 0) ? Z : 7'($urandom_range(0, 9));
        s.rn = ($urandom_range(0, 7) == 0) ? Z : 7'($urandom_range(0, 9));
        return s;
    endfunction

    task automatic do_reset();
        drive(1, 0, sl(UCMD_ADD, 1, 2, 3), sl(UCMD_XOR, 4, 5, 6));
        reset = 1'b0;
        #1 chk("rst_idReady", 32'(idReady), 32'd0);
        @(negedge clock);
        @(negedge clock);
        drive(0, 0, sl(UCMD_NONE, Z, Z, Z), sl(UCMD_NONE, Z, Z, Z));
        reset = 1'b1;
        m_reset();
    endtask

    vec_t tbl [18];
    bit   r;
    int   stalls;
    slot_t NO;

    initial begin
        NO = sl(UCMD_NONE, Z, Z, Z);
        reset = 1'b1;
        drive(0, 0, NO, NO);
        @(negedge clock);
        do_reset();

        // Reset state of every output.
        chk("rst_priValid", 32'(priValid), 32'd0);
        chk("rst_secValid", 32'(secValid), 32'd0);
        chk("rst_priOp",    32'(priOp), 32'(UCMD_NONE));
        chk("rst_priRs",    32'(priRs), 32'(Z));
        chk("rst_priRn",    32'(priRn), 32'(Z));
        chk("rst_secOp",    32'(secOp), 32'(UCMD_NONE));
        chk("rst_secRn",    32'(secRn), 32'(Z));
        chk("rst_stats",    statPair | statSplit | statStall, 32'd0);

        // ---------------- vector table (rows run back to back) ----------------
        tbl[0]  = mk(1,0, sl(UCMD_ADD,1,2,3),    sl(UCMD_XOR,4,5,6),   1, 1,UCMD_ADD,1,    1,UCMD_XOR,4);
        tbl[1]  = mk(1,0, sl(UCMD_ADD,1,2,3),    sl(UCMD_SUB,7,1,4),   1, 1,UCMD_ADD,1,    0,UCMD_NONE,Z);
        tbl[2]  = mk(1,0, NO,                    sl(UCMD_AND,9,10,11), 0, 1,UCMD_SUB,7,    0,UCMD_NONE,Z);
        tbl[3]  = mk(1,0, NO,                    sl(UCMD_AND,9,10,11), 1, 1,UCMD_AND,9,    0,UCMD_NONE,Z);
        tbl[4]  = mk(1,0, sl(UCMD_SUB,2,3,4),    NO,                   1, 1,UCMD_SUB,2,    0,UCMD_NONE,Z);
        tbl[5]  = mk(1,0, sl(UCMD_OR,3,4,5),     sl(UCMD_ADDC,2,2,3),  1, 1,UCMD_OR,3,     0,UCMD_NONE,Z);
        tbl[6]  = mk(0,0, NO,                    NO,                   0, 1,UCMD_ADDC,2,   0,UCMD_NONE,Z);
        tbl[7]  = mk(1,0, sl(UCMD_MOV_RI,5,Z,Z), sl(UCMD_NOT,5,6,Z),   1, 1,UCMD_MOV_RI,5, 0,UCMD_NONE,Z);
        tbl[8]  = mk(0,0, NO,                    NO,                   0, 1,UCMD_NOT,5,    0,UCMD_NONE,Z);
        tbl[9]  = mk(1,0, sl(UCMD_ADD,Z,1,2),    sl(UCMD_SUB,Z,3,4),   1, 1,UCMD_ADD,Z,    1,UCMD_SUB,Z);
        tbl[10] = mk(1,1, sl(UCMD_ADD,1,2,3),    sl(UCMD_XOR,4,5,6),   0, 0,UCMD_NONE,Z,   0,UCMD_NONE,Z);
        tbl[11] = mk(0,0, NO,                    NO,                   0, 0,UCMD_NONE,Z,   0,UCMD_NONE,Z);
        tbl[12] = mk(1,0, sl(UCMD_XOR,1,2,3),    sl(UCMD_MUL,8,4,5),   1, 1,UCMD_XOR,1,    0,UCMD_NONE,Z);
        tbl[13] = mk(0,0, NO,                    NO,                   0, 1,UCMD_MUL,8,    0,UCMD_NONE,Z);
        tbl[14] = mk(1,0, sl(UCMD_ADD,1,2,3),    sl(UCMD_MOV_RR,9,8,Z),1, 1,UCMD_ADD,1,    0,UCMD_NONE,Z);
        tbl[15] = mk(0,0, NO,                    NO,                   0, 0,UCMD_NONE,Z,   0,UCMD_NONE,Z);
        tbl[16] = mk(0,0, NO,                    NO,                   0, 0,UCMD_NONE,Z,   0,UCMD_NONE,Z);
        tbl[17] = mk(0,0, NO,                    NO,                   0, 1,UCMD_MOV_RR,9, 0,UCMD_NONE,Z);

        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].v, tbl[i].h, tbl[i].a, tbl[i].b, r);
            chk($sformatf("vec%0d_idReady", i), 32'(r), 32'(tbl[i].rdy));
            chk_out($sformatf("vec%0d", i), tbl[i].pv, tbl[i].pop, tbl[i].prn,
                    tbl[i].sv, tbl[i].sop, tbl[i].srn);
        end

        // ---------------- MUL -> dependent MOV stalls exactly LONG_LAT ----------------
        do_reset();
        cyc(1, 0, sl(UCMD_MUL, 8, 1, 2), NO, r);
        chk("mul_accept", 32'(r), 32'd1);
        chk_out("mul_issue", 1, UCMD_MUL, 8, 0, UCMD_NONE, Z);
        stalls = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(1, 0, sl(UCMD_MOV_RR, 9, 8, Z), NO, r);
            if (r) break;
            stalls++;
        end
        chk("mul_stall_cycles", 32'(stalls), 32'(LL));
        chk_out("mov_after_mul", 1, UCMD_MOV_RR, 9, 0, UCMD_NONE, Z);

        // ---------------- exHold during SPLIT freezes scoreboard ----------------
        do_reset();
        cyc(1, 0, sl(UCMD_MUL, 3, 1, 2), NO, r);
        cyc(1, 0, sl(UCMD_ADD, 5, 1, 2), sl(UCMD_NEG, 5, 5, Z), r);
        chk("hold_split_accept", 32'(r), 32'd1);
        chk_out("hold_split_a", 1, UCMD_ADD, 5, 0, UCMD_NONE, Z);
        for (int k = 0; k < 2; k++) begin
            cyc(1, 1, sl(UCMD_MOV_RR, 4, 3, Z), NO, r);
            chk($sformatf("hold%0d_idReady", k), 32'(r), 32'd0);
            chk_out($sformatf("hold%0d", k), 0, UCMD_NONE, Z, 0, UCMD_NONE, Z);
        end
        cyc(1, 0, sl(UCMD_MOV_RR, 4, 3, Z), NO, r);
        chk("hold_release_idReady", 32'(r), 32'd0);
        chk_out("hold_release_neg", 1, UCMD_NEG, 5, 0, UCMD_NONE, Z);
        stalls = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(1, 0, sl(UCMD_MOV_RR, 4, 3, Z), NO, r);
            if (r) break;
            stalls++;
        end
        chk("frozen_sb_stall_cycles", 32'(stalls), 32'd1);
        chk_out("mov_after_freeze", 1, UCMD_MOV_RR, 4, 0, UCMD_NONE, Z);

        // ---------------- reset asserted in SPLIT ----------------
        do_reset();
        cyc(1, 0, sl(UCMD_ADD, 1, 2, 3), sl(UCMD_SUB, 7, 1, 4), r);
        chk_out("pre_rst_split", 1, UCMD_ADD, 1, 0, UCMD_NONE, Z);
        reset = 1'b0;
        #1;
        chk("midrst_priValid", 32'(priValid), 32'd0);
        chk("midrst_secValid", 32'(secValid), 32'd0);
        chk("midrst_priRn",    32'(priRn), 32'(Z));
        chk("midrst_priOp",    32'(priOp), 32'(UCMD_NONE));
        chk("midrst_secRn",    32'(secRn), 32'(Z));
        chk("midrst_stats",    statPair | statSplit | statStall, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        m_reset();
        cyc(0, 0, NO, NO, r);
        chk_out("held_discarded", 0, UCMD_NONE, Z, 0, UCMD_NONE, Z);

        // ---------------- randomized run against the model ----------------
        do_reset();
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 4) != 0, $urandom_range(0, 6) == 0, rnd_slot(), rnd_slot());
            m_cycle();
            #1 chk($sformatf("rnd%0d_idReady", k), 32'(idReady), 32'(m_ready));
            @(posedge clock);
            @(negedge clock);
            chk_out($sformatf("rnd%0d", k), e_pv, e_pri.op, e_pri.rn, e_sv, e_sec.op, e_sec.rn);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exop_dual_issue_ctl.md
Name: exop_dual_issue_ctl

Overview:
- Issue controller sitting between ID and the two execute units: primary (full: memory, MUL, shift, SR) and secondary (ALU-only: MOV, add/sub, logic, extend/swap, NEG, LDSH16).
- Each cycle it takes a decoded pair (slot A, slot B) and chooses one of three actions: dual-issue, split (A now, B next cycle), or stall.
- It tracks long-latency destinations with a small countdown scoreboard and applies backpressure to ID.

Parameters:
- LONG_LAT, 3, cycles a MUL/load destination stays busy after issue (1..7).
- NREG, 128, register id space (7-bit ids, UREG_ZZR = no register).
- STAT_W, 32, width of the optional performance counters.

Ports:
- clock  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- idValid  in  1  pair presented by ID
- idOpA / idOpB  in  8  UCMD opcodes for slots A/B (UCMD_NONE = empty slot)
- idRsA,idRtA,idRnA / idRsB,idRtB,idRnB  in  7 each  register ids
- idReady  out  1  pair accepted this cycle
- exHold  in  1  primary unit reports UMEM_OK_HOLD (primary not accepting)
- priValid / priOp / priRs / priRt / priRn  out  1/8/7/7/7  issue to primary
- secValid / secOp / secRs / secRt / secRn  out  1/8/7/7/7  issue to secondary
- statPair / statSplit / statStall  out  STAT_W each  counters (optional feature only)

Behaviour:
- Reset (reset=0, async): FSM=RUN, scoreboard cleared, held slot cleared, idReady=0, priValid=0, secValid=0, all ids=UREG_ZZR, all ops=UCMD_NONE, counters=0.
- All issue outputs are registered: one cycle latency from acceptance to valid. idReady is combinational from the current state and inputs.
- Secondary-capable set: MOV_RR, MOV_RI, ADD, SUB, AND, OR, XOR, NOT, SWAPB, SWAPW, EXTU/EXTS B/W, NEG, LDSH16. Everything else goes only to primary, including ADDC/SUBC/NEGC/ADDV/SUBV, because the secondary unit drops SR effects.
- Busy(id): scoreboard counter for id is nonzero. UREG_ZZR is never busy.
- Hazard(slot): any of the slot's Rs/Rt/Rn is busy.
- Pairable: all of the following hold:
  - B is secondary-capable.
  - idRnA is not idRsB or idRtB (RAW).
  - idRnA is not idRnB, unless both are ZZR (WAW).
  - No hazard on either slot.
- States:
  - RUN: if exHold or !idValid → no issue, idReady=0. Else if Hazard(A) → stall, idReady=0. Else if Pairable → issue A to primary and B to secondary, idReady=1. Else issue A to primary, latch B into the held slot, idReady=1, go to SPLIT.
  - SPLIT: idReady=0. If exHold or Hazard(held) → wait. Else issue held to primary, clear held, go to RUN. The held op never goes to the secondary.
- Empty slot handling: if idOpA=UCMD_NONE and B is valid, B is promoted to A. If idOpB=UCMD_NONE, the pair is treated as pairable with secValid=0.
- Scoreboard: when an op issued to primary is MUL or any load, set cnt[priRn]=LONG_LAT. Every cycle, each nonzero counter decrements unless exHold=1 (the counters freeze while the primary stalls). If a set and a decrement hit the same id in one cycle, the set wins.
- exHold=1: priValid/secValid drop to 0 the next cycle. Issue regs keep their last ids.
- Reset mid-SPLIT: the held op is discarded. ID must re-present it; ID flush owns that.

Optional Feature:
- EXOP_ISSUE_STATS_EN.
- Defined: statPair, statSplit and statStall each count cycles of dual-issue, split-issue and stall (exHold, hazard or SPLIT-wait). They saturate at all-ones and clear on reset.
- Undefined: stat ports are tied to 0 and the counter logic is removed.

Decomposition:
- Shared package/include (CoreDefs.v): UCMD_* opcodes, UREG_ZZR, UMEM_OK_*, and a new macro list UCMD_SEC_CAPABLE plus the long-latency opcode set.
- One sub-module: exop_issue_scoreboard. It holds the per-register 3-bit counters, set/decrement/freeze logic, and a 3-read busy lookup per slot.

Test Plan:
- A=ADD R1←R2,R3; B=XOR R4←R5,R6 → next cycle priValid=1 (ADD, Rn=1), secValid=1 (XOR, Rn=4), idReady=1.
- A=ADD R1←R2,R3; B=SUB R7←R1,R4 (RAW) → cycle 1: pri=ADD, secValid=0. Cycle 2: pri=SUB, Rn=7. idReady=0 in SPLIT.
- A=MUL Rn=R8, then next pair A=MOV_RR R9←R8 → stall exactly LONG_LAT=3 cycles, then MOV issues on primary.
- B=ADDC R2←R2,R3 with an unrelated A → split-issue; ADDC issues only on primary.
- exHold=1 for 2 cycles during SPLIT holding NEG R5 → scoreboard frozen, no issue; NEG issues on primary the cycle after exHold falls.
- Reset asserted during SPLIT → outputs immediately priValid=secValid=0, ids=UREG_ZZR; with EXOP_ISSUE_STATS_EN, stat counters read 0.
